// File: rtl/pi_vel_pkg.sv
// pi_vel_pkg: shared FSM state type, gain format and saturation helpers for
// the PI velocity controller.
package pi_vel_pkg;

    // Control-step sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_MUL,
        ST_INT,
        ST_SUM
    } state_t;

    // Gain format: unsigned Q8.8.
    localparam int GAIN_W        = 16;
    localparam int GAIN_FRAC_DEF = 8;

    // Velocity words and default error clamp width.
    localparam int VEL_W     = 32;
    localparam int ERR_W_DEF = 24;

    // Signed product width: error times a zero-extended unsigned gain.
    function automatic int prod_w(input int err_w);
        return err_w + GAIN_W + 1;
    endfunction

    // Largest magnitude representable symmetrically in a w-bit signed word.
    function automatic longint sym_limit(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/pi_vel_controller_pwm_gen.sv
// pwm_gen: free-running PWM with a duty that is only reloaded on the period
// wrap, so the output never glitches mid-period.
module pwm_gen #(
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_W     = 16
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_out
);
    localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

    logic [DUTY_W-1:0] cnt_q;
    logic [DUTY_W-1:0] applied_q;
    logic              pwm_q;

    // Period counter, wrap-synchronous duty reload and registered comparator.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q     <= '0;
            applied_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_q     <= '0;
                applied_q <= duty;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            pwm_q <= (cnt_q < applied_q);
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/pi_vel_controller.sv
// pi_vel_controller: multi-cycle PI velocity loop producing a saturated
// signed command (duty magnitude + direction) and a PWM drive.
// Optional build macro PI_ANTIWINDUP_EN enables conditional integration
// (integrator held while the last command saturated in the error's direction).
module pi_vel_controller
    import pi_vel_pkg::*;
#(
    parameter int GAIN_FRAC  = GAIN_FRAC_DEF,
    parameter int DUTY_W     = 16,
    parameter int PWM_PERIOD = 1000,
    parameter int DUTY_MAX   = 1000,
    parameter int INTEG_LIM  = 1000,
    parameter int ERR_W      = ERR_W_DEF
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              ctrl_en,
    input  logic              sample_tick,
    input  logic [GAIN_W-1:0] kp_init,
    input  logic [GAIN_W-1:0] ki_init,
    input  logic [VEL_W-1:0]  desired_vel,
    input  logic [VEL_W-1:0]  actual_vel,
    output logic [DUTY_W-1:0] duty,
    output logic              motor_dir,
    output logic              duty_valid,
    output logic              pwm_out,
    output logic              overrun
);
    localparam int PROD_W = prod_w(ERR_W);
    localparam int ACC_W  = PROD_W + 1;   // headroom for integ/p additions
    localparam int DIFF_W = VEL_W + 1;    // exact difference of two velocities

    localparam logic signed [DIFF_W-1:0] ERR_MAX   = DIFF_W'(sym_limit(ERR_W));
    localparam logic signed [ACC_W-1:0]  INTEG_MAX = ACC_W'(INTEG_LIM);
    localparam logic signed [ACC_W-1:0]  U_MAX     = ACC_W'(DUTY_MAX);

    state_t                    state_q;
    logic signed [VEL_W-1:0]   des_q, act_q;
    logic signed [ERR_W-1:0]   err_q, err_d;
    logic        [GAIN_W-1:0]  kp_q, ki_q;
    logic signed [PROD_W-1:0]  p_q, p_d, inc_q, inc_d;
    logic signed [PROD_W-1:0]  err_ext, kp_ext, ki_ext;
    logic signed [ACC_W-1:0]   integ_q, integ_d, integ_sum;
    logic signed [ACC_W-1:0]   u_sum, u_d;
    logic signed [DIFF_W-1:0]  diff;
    logic        [DUTY_W-1:0]  duty_q;
    logic                      dir_q, dv_q, overrun_q;
    logic                      hold_integ;
`ifdef PI_ANTIWINDUP_EN
    logic                      sat_q, sat_neg_q;
`endif

    // Datapath for each step: error clamp, gain products, integrator and command saturation.
    always_comb begin
        diff = $signed({des_q[VEL_W-1], des_q}) - $signed({act_q[VEL_W-1], act_q});
        if (diff > ERR_MAX)
            err_d = ERR_W'(ERR_MAX);
        else if (diff < -ERR_MAX)
            err_d = ERR_W'(-ERR_MAX);
        else
            err_d = ERR_W'(diff);

        err_ext = {{(PROD_W-ERR_W){err_q[ERR_W-1]}}, err_q};
        kp_ext  = {{(PROD_W-GAIN_W){1'b0}}, kp_q};
        ki_ext  = {{(PROD_W-GAIN_W){1'b0}}, ki_q};
        p_d     = (err_ext * kp_ext) >>> GAIN_FRAC;
        inc_d   = (err_ext * ki_ext) >>> GAIN_FRAC;

        integ_sum = integ_q + {{(ACC_W-PROD_W){inc_q[PROD_W-1]}}, inc_q};
        if (integ_sum > INTEG_MAX)
            integ_d = INTEG_MAX;
        else if (integ_sum < -INTEG_MAX)
            integ_d = -INTEG_MAX;
        else
            integ_d = integ_sum;

        u_sum = integ_q + {{(ACC_W-PROD_W){p_q[PROD_W-1]}}, p_q};
        if (u_sum > U_MAX)
            u_d = U_MAX;
        else if (u_sum < -U_MAX)
            u_d = -U_MAX;
        else
            u_d = u_sum;

`ifdef PI_ANTIWINDUP_EN
        // Do not push further into a saturation the error is still driving.
        hold_integ = sat_q && ((err_q > 0 && !sat_neg_q) || (err_q < 0 && sat_neg_q));
`else
        hold_integ = 1'b0;
`endif
    end

    // Control-step sequencer with registered command outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            des_q     <= '0;
            act_q     <= '0;
            err_q     <= '0;
            kp_q      <= '0;
            ki_q      <= '0;
            p_q       <= '0;
            inc_q     <= '0;
            integ_q   <= '0;
            duty_q    <= '0;
            dir_q     <= 1'b0;
            dv_q      <= 1'b0;
            overrun_q <= 1'b0;
`ifdef PI_ANTIWINDUP_EN
            sat_q     <= 1'b0;
            sat_neg_q <= 1'b0;
`endif
        end else if (!ctrl_en) begin
            // Disabling the loop abandons any step and zeroes the command.
            state_q <= ST_IDLE;
            integ_q <= '0;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            dv_q    <= 1'b0;
`ifdef PI_ANTIWINDUP_EN
            sat_q   <= 1'b0;
`endif
        end else begin
            dv_q <= 1'b0;
            if (sample_tick && state_q != ST_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (sample_tick) begin
                        des_q   <= desired_vel;
                        act_q   <= actual_vel;
                        state_q <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    err_q   <= err_d;
                    kp_q    <= kp_init;
                    ki_q    <= ki_init;
                    state_q <= ST_MUL;
                end
                ST_MUL: begin
                    p_q     <= p_d;
                    inc_q   <= inc_d;
                    state_q <= ST_INT;
                end
                ST_INT: begin
                    if (!hold_integ)
                        integ_q <= integ_d;
                    state_q <= ST_SUM;
                end
                ST_SUM: begin
                    duty_q  <= DUTY_W'(u_d[ACC_W-1] ? -u_d : u_d);
                    dir_q   <= u_d[ACC_W-1];
                    dv_q    <= 1'b1;
`ifdef PI_ANTIWINDUP_EN
                    sat_q     <= (u_sum > U_MAX) || (u_sum < -U_MAX);
                    sat_neg_q <= u_sum[ACC_W-1];
`endif
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pwm_gen #(
        .PWM_PERIOD(PWM_PERIOD),
        .DUTY_W    (DUTY_W)
    ) u_pwm (
        .aclk   (aclk),
        .areset (areset),
        .duty   (duty_q),
        .pwm_out(pwm_out)
    );

    assign duty       = duty_q;
    assign motor_dir  = dir_q;
    assign duty_valid = dv_q;
    assign overrun    = overrun_q;

endmodule

// File: doc/pi_vel_controller.md
Name: pi_vel_controller

Overview:
- PI velocity loop; consumes the gain and setpoint registers exported by the AXI-lite register block (kp_init, ki_init, desired_vel) plus the measured actual_vel from the encoder velocity stage.
- Once per control period (sample_tick), computes a saturated signed command and drives motor_dir and a glitch-free PWM output to the H-bridge.
- Sits directly downstream of the AXI register block.

Parameters:
- GAIN_FRAC, 8: fractional bits of kp/ki (unsigned Q8.8).
- DUTY_W, 16: duty/PWM counter width.
- PWM_PERIOD, 1000: PWM period in aclk cycles, must be < 2^DUTY_W.
- DUTY_MAX, 1000: command magnitude limit, ≤ PWM_PERIOD.
- INTEG_LIM, 1000: integrator magnitude clamp, command units.
- ERR_W, 24: error clamp width, signed.

Ports:
- aclk  in  1  system clock (same as s00_axi_aclk).
- areset  in  1  synchronous, active-high reset.
- ctrl_en  in  1  loop enable.
- sample_tick  in  1  one-cycle control-period strobe.
- kp_init  in  16  proportional gain, Q8.8.
- ki_init  in  16  integral gain, Q8.8.
- desired_vel  in  32  signed setpoint.
- actual_vel  in  32  signed measurement.
- duty  out  DUTY_W  current command magnitude.
- motor_dir  out  1  1 = negative command.
- duty_valid  out  1  one-cycle pulse when duty/motor_dir update.
- pwm_out  out  1  PWM drive.
- overrun  out  1  sticky: tick arrived while busy.

Behaviour:
- Interface: one clock, aclk. areset is synchronous, active-high.
- Reset values: all outputs 0, integrator 0, FSM IDLE, PWM counter 0, applied duty 0. Reset mid-computation aborts the computation and produces no duty_valid.
- FSM states: IDLE, ERR, MUL, INT, SUM.
  - IDLE: on sample_tick && ctrl_en, latch desired_vel/actual_vel, go to ERR.
  - ERR: err = desired − actual as 33-bit signed, clamped to ±(2^(ERR_W−1)−1); latch kp/ki. Gains are frozen for the whole computation.
  - MUL: p = (err*kp) >>> GAIN_FRAC; i_inc = (err*ki) >>> GAIN_FRAC. Arithmetic shift, truncates toward −inf; products are 41-bit signed.
  - INT: integ += i_inc, clamped to ±INTEG_LIM.
  - SUM: u = p + integ, saturated to ±DUTY_MAX. duty = |u|, motor_dir = (u<0). Pulse duty_valid. Go to IDLE.
- Latency: tick at cycle T gives duty_valid at T+4. Maximum tick rate is 1 per 5 cycles.
- sample_tick outside IDLE: ignored, overrun set (sticky until areset).
- ctrl_en low, any state: next cycle FSM to IDLE, integ 0, duty 0, motor_dir 0, no duty_valid. Ticks with ctrl_en low are ignored and do not set overrun.
- Simultaneous tick and ctrl_en fall: ctrl_en wins.
- u = 0 gives motor_dir 0.
- PWM:
  - Counter runs 0..PWM_PERIOD−1, then wraps to 0.
  - Applied duty loads from duty only when the counter is at PWM_PERIOD−1, i.e. on wrap; no mid-period change.
  - pwm_out = (cnt < applied_duty), registered. Duty 0 gives constant low.
  - motor_dir is not re-timed to the PWM period.

Optional Feature:
- Macro PI_ANTIWINDUP_EN.
- Defined: conditional integration. INT skips the update (integ held) when the previous SUM saturated (|u_unsat| > DUTY_MAX) and sign(err) equals sign of that saturated command. The saturation flag is cleared by areset and by ctrl_en low.
- Undefined: integrator limited only by the INTEG_LIM clamp.

Decomposition:
- Package pi_vel_pkg: FSM state enum; localparams for product width (ERR_W+17), gain Q format, and saturation helper constants.
- One sub-module: pwm_gen (counter, wrap-synchronous duty load, comparator). Parameters PWM_PERIOD and DUTY_W; inputs duty, aclk, areset; output pwm_out.

Test Plan:
- Reset: assert areset 3 cycles mid-PWM → duty=0, motor_dir=0, pwm_out=0, overrun=0; no duty_valid afterwards.
- P only: kp=0x0100, ki=0, desired=300, actual=100, ctrl_en=1, tick → duty_valid exactly 4 cycles later, duty=200, motor_dir=0. Next PWM period: pwm_out high 200 of 1000 cycles.
- I accumulation: kp=0, ki=0x0080, err=100, 3 ticks → duty 50, 100, 150. Then 20 more ticks → duty holds at 1000 (INTEG_LIM).
- Negative saturation: kp=0x0100, ki=0, desired=0, actual=5000 → duty=1000, motor_dir=1. With actual=2^31−1, err is clamped to 8388607 and there is no wrap.
- Anti-windup: kp=0x0100, ki=0x0100, err=600, 2 ticks, then err=0, 1 tick → duty=600 with PI_ANTIWINDUP_EN, 1000 without.
- Overrun/enable: tick, then second tick 2 cycles later → overrun=1, first result unchanged (duty per stimulus). ctrl_en=0 during MUL → no duty_valid, duty=0, integrator cleared.
